branch_resolve_queue: RTL and testbench
=======================================

# branch_resolve_queue

Tracks every branch/jump the fetch stage predicts, in program order, until execute resolves it. At resolution it compares outcome to prediction, raises a one-cycle flush with the recovery PC on a mispredict, and drives the training write port (en / write_addr / was_taken) of the 2-bit branch history table. Sits between fetch (producer of predictions) and execute (producer of outcomes), directly downstream of the branch history table's prediction output.

## Interface
- LOWER, 5, table index width; index = pc[LOWER+1:2]
- ADDR_W, 64, PC width
- DEPTH, 4, in-flight entries, power of two, ≥2
- clk  in  1  clock
- arst_n  in  1  reset, asynchronous, active-low
- fetch_valid  in  1  predicted branch/jump fetched this cycle (push)
- fetch_pc  in  ADDR_W  PC of that instruction
- fetch_pred_taken  in  1  prediction bit from the history table
- fetch_pred_target  in  ADDR_W  predicted target (ignored when not predicted taken)
- full  out  1  DEPTH entries held; fetch must stall
- res_valid  in  1  execute resolves the oldest entry (pop)
- res_taken  in  1  actual direction (jumps always 1)
- res_target  in  ADDR_W  actual target
- flush  out  1  mispredict pulse, registered
- redirect_pc  out  ADDR_W  recovery PC, valid while flush=1
- bht_en  out  1  training write strobe, registered
- bht_write_addr  out  LOWER  index of resolved entry
- bht_was_taken  out  1  actual direction of resolved entry
- count  out  clog2(DEPTH)+1  occupancy
- err  out  1  sticky: push when full or pop when empty

## Operation
- Entry = {pc, pred_taken, pred_target}; circular buffer, wr/rd pointers wrap modulo DEPTH, count tracks occupancy.
- Push: fetch_valid=1 and flush=0 and (count<DEPTH or same-cycle pop) → store at wr_ptr.
- Pop: res_valid=1 and count>0 → read entry at rd_ptr.
- Mispredict if res_taken≠pred_taken, or res_taken=1 and res_target≠pred_target.
- Recovery PC: res_taken ? res_target : pc+4 (ADDR_W wrap-around, no carry out).
- On mispredict: all entries discarded (count→0, wr_ptr=rd_ptr=0); same-cycle push dropped.
- Every pop (correct or not) produces one bht_en pulse with index and direction.
- Pushes ignored while flush=1 (wrong-path fetch).
- Push when full without pop: dropped, err set. Pop when empty: ignored, no bht_en, no flush, err set. err cleared only by reset.
- full = (count==DEPTH), combinational from count.

## Timing
- Reset: flush=0, redirect_pc=0, bht_en=0, bht_write_addr=0, bht_was_taken=0, count=0, full=0, err=0, pointers 0. Reset mid-operation discards all entries immediately.
- Pop at edge N → flush, redirect_pc, bht_en, bht_write_addr, bht_was_taken valid in cycle N+1 for exactly one cycle.
- Push at edge N → count incremented in cycle N+1; entry poppable from edge N+1.
- Simultaneous push/pop: count unchanged; legal when full.
- Back-to-back pops: one bht_en per cycle, no bubble.
- Flush and err never depend combinationally on inputs.

## Structure
- Shared package/include branch_pkg: INSTR_BYTES=4, LOWER and ADDR_W defaults, entry field widths and entry packing offsets; also used by the history table and fetch stage.
- Sub-module brq_fifo: parameterised circular buffer (width, DEPTH, push/pop/clear, count); compare/redirect/training logic stays in the top.

## Test plan
- Reset, push pc=0x40 pred_taken=1 target=0x80, pop res_taken=1 res_target=0x80 → next cycle bht_en=1, bht_write_addr=0x10, bht_was_taken=1, flush=0.
- Push pc=0x100 pred_taken=1, pop res_taken=0 → flush=1 one cycle, redirect_pc=0x104, bht_was_taken=0, count=0.
- Push 3 entries, oldest mispredicts (taken, target 0x200 vs predicted 0x1F0) → flush=1, redirect_pc=0x200, count=0, later pop on empty sets err=1, no bht_en.
- Fill to DEPTH=4 → full=1; push+pop same cycle → count stays 4, err=0; extra push alone → dropped, err=1.
- fetch_pc=0xFFFF_FFFF_FFFF_FFFC predicted taken, resolved not taken → redirect_pc=0 (wrap).
- Assert arst_n=0 with 2 entries and pending flush → all outputs 0 immediately; after release, count=0 and first push/pop behaves normally.

Source files
------------

// File: rtl/branch_pkg.sv
// branch_pkg: shared branch-path constants and entry layout used by the BHT, fetch and the resolve queue
package branch_pkg;
    localparam int INSTR_BYTES = 4;
    localparam int LOWER_DEF   = 5;
    localparam int ADDR_W_DEF  = 64;
    localparam int DEPTH_DEF   = 4;

    function automatic int entry_w(input int aw);
        return 2 * aw + 1;
    endfunction

    function automatic int entry_pc_lsb(input int aw);
        return aw + 1;
    endfunction

    function automatic int entry_taken_bit(input int aw);
        return aw;
    endfunction

    function automatic int entry_target_lsb(input int aw);
        return 0 * aw;
    endfunction
endpackage

// File: rtl/branch_resolve_queue_if.sv
// branch_resolve_queue_if: fetch-prediction, execute-resolution and BHT-training signals of the resolve queue
interface branch_resolve_queue_if
    import branch_pkg::*;
#(
    parameter int LOWER  = LOWER_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
);
    localparam int CW = $clog2(DEPTH) + 1;
    logic              fetch_valid;
    logic [ADDR_W-1:0] fetch_pc;
    logic              fetch_pred_taken;
    logic [ADDR_W-1:0] fetch_pred_target;
    logic              full;
    logic              res_valid;
    logic              res_taken;
    logic [ADDR_W-1:0] res_target;
    logic              flush;
    logic [ADDR_W-1:0] redirect_pc;
    logic              bht_en;
    logic [LOWER-1:0]  bht_write_addr;
    logic              bht_was_taken;
    logic [CW-1:0]     count;
    logic              err;

    modport master (
        output fetch_valid, fetch_pc, fetch_pred_taken, fetch_pred_target,
        output res_valid, res_taken, res_target,
        input  full, flush, redirect_pc, bht_en, bht_write_addr, bht_was_taken, count, err
    );

    modport slave (
        input  fetch_valid, fetch_pc, fetch_pred_taken, fetch_pred_target,
        input  res_valid, res_taken, res_target,
        output full, flush, redirect_pc, bht_en, bht_write_addr, bht_was_taken, count, err
    );
endinterface

// File: rtl/brq_fifo.sv
// brq_fifo: circular buffer with push/pop/clear and occupancy count; caller guarantees no overflow or underflow
module brq_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       arst_n,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic                       clear_i,
    input  logic [WIDTH-1:0]           wr_data_i,
    output logic [WIDTH-1:0]           rd_data_o,
    output logic [$clog2(DEPTH):0]     count_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    // next pointers and occupancy; clear wins over any push/pop in the same cycle
    always_comb begin
        wr_d  = clear_i ? '0 : wr_q + PW'(push_i);
        rd_d  = clear_i ? '0 : rd_q + PW'(pop_i);
        cnt_d = clear_i ? '0 : cnt_q + CW'(push_i) - CW'(pop_i);
    end

    // pointer and count registers
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // entry storage, written at the write pointer
    always_ff @(posedge clk) begin
        if (push_i && !clear_i) mem_q[wr_q] <= wr_data_i;
    end

    assign rd_data_o = mem_q[rd_q];
    assign count_o   = cnt_q;
endmodule

// File: rtl/branch_resolve_queue.sv
// branch_resolve_queue: holds predicted branches in order, checks them at resolution, flushes and trains the BHT
module branch_resolve_queue
    import branch_pkg::*;
#(
    parameter int LOWER  = LOWER_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input logic                   clk,
    input logic                   arst_n,
    branch_resolve_queue_if.slave brq_if
);
    localparam int EW      = entry_w(ADDR_W);
    localparam int PC_LSB  = entry_pc_lsb(ADDR_W);
    localparam int PT_BIT  = entry_taken_bit(ADDR_W);
    localparam int TGT_LSB = entry_target_lsb(ADDR_W);
    localparam int CW      = $clog2(DEPTH) + 1;

    logic [EW-1:0]     wr_entry, rd_entry;
    logic [ADDR_W-1:0] rd_pc, rd_tgt;
    logic              rd_pt;
    logic [CW-1:0]     count;
    logic              push_req, push, pop, mispredict, full;
    logic              flush_q, flush_d;
    logic [ADDR_W-1:0] redirect_q, redirect_d;
    logic              bht_en_q, bht_en_d;
    logic [LOWER-1:0]  bht_addr_q, bht_addr_d;
    logic              bht_taken_q, bht_taken_d;
    logic              err_q, err_d;

    assign wr_entry = {brq_if.fetch_pc, brq_if.fetch_pred_taken, brq_if.fetch_pred_target};
    assign rd_pc    = rd_entry[PC_LSB +: ADDR_W];
    assign rd_pt    = rd_entry[PT_BIT];
    assign rd_tgt   = rd_entry[TGT_LSB +: ADDR_W];

    brq_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .arst_n    (arst_n),
        .push_i    (push),
        .pop_i     (pop),
        .clear_i   (mispredict),
        .wr_data_i (wr_entry),
        .rd_data_o (rd_entry),
        .count_o   (count)
    );

    // resolve the oldest entry, decide push acceptance and compute the next registered outputs
    always_comb begin
        push_req    = brq_if.fetch_valid & ~flush_q;
        pop         = brq_if.res_valid & (count != '0);
        mispredict  = pop & ((brq_if.res_taken != rd_pt) | (brq_if.res_taken & (brq_if.res_target != rd_tgt)));
        full        = count == CW'(DEPTH);
        push        = push_req & (~full | pop) & ~mispredict;
        flush_d     = mispredict;
        redirect_d  = mispredict ? (brq_if.res_taken ? brq_if.res_target : rd_pc + ADDR_W'(INSTR_BYTES)) : '0;
        bht_en_d    = pop;
        bht_addr_d  = pop ? rd_pc[LOWER+1:2] : '0;
        bht_taken_d = pop & brq_if.res_taken;
        err_d       = err_q | (push_req & full & ~pop) | (brq_if.res_valid & (count == '0));
    end

    // one-cycle flush/training pulses and the sticky error flag
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            flush_q     <= 1'b0;
            redirect_q  <= '0;
            bht_en_q    <= 1'b0;
            bht_addr_q  <= '0;
            bht_taken_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            flush_q     <= flush_d;
            redirect_q  <= redirect_d;
            bht_en_q    <= bht_en_d;
            bht_addr_q  <= bht_addr_d;
            bht_taken_q <= bht_taken_d;
            err_q       <= err_d;
        end
    end

    assign brq_if.full           = full;
    assign brq_if.flush          = flush_q;
    assign brq_if.redirect_pc    = redirect_q;
    assign brq_if.bht_en         = bht_en_q;
    assign brq_if.bht_write_addr = bht_addr_q;
    assign brq_if.bht_was_taken  = bht_taken_q;
    assign brq_if.count          = count;
    assign brq_if.err            = err_q;
endmodule

// File: tb/tb_branch_resolve_queue.sv
// tb_branch_resolve_queue: directed and random stimulus against an in-order queue reference model
module tb_branch_resolve_queue;
    import branch_pkg::*;
    localparam int LOWER  = 5;
    localparam int ADDR_W = 64;
    localparam int DEPTH  = 4;

    typedef struct {
        logic [63:0] pc;
        logic        pt;
        logic [63:0] tgt;
    } ent_t;

    logic clk = 1'b0;
    logic arst_n = 1'b1;
    always #5 clk = ~clk;

    branch_resolve_queue_if #(.LOWER(LOWER), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) bus ();

    branch_resolve_queue #(.LOWER(LOWER), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk    (clk),
        .arst_n (arst_n),
        .brq_if (bus)
    );

    ent_t        mq[$];
    logic        m_flush, m_en, m_wt, m_err;
    logic [63:0] m_redir;
    logic [4:0]  m_addr;
    int          total = 0;
    int          bad = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        m_flush = 0; m_en = 0; m_wt = 0; m_err = 0; m_redir = 0; m_addr = 0;
    endtask

    task automatic compare_all();
        check("flush", bus.flush, m_flush);
        if (m_flush) check("redirect", bus.redirect_pc, m_redir);
        check("bht_en", bus.bht_en, m_en);
        if (m_en) begin
            check("bht_addr", bus.bht_write_addr, m_addr);
            check("bht_taken", bus.bht_was_taken, m_wt);
        end
        check("count", bus.count, mq.size());
        check("full", bus.full, mq.size() == DEPTH);
        check("err", bus.err, m_err);
    endtask

    task automatic step(input logic fv, input logic [63:0] pc, input logic pt, input logic [63:0] ptgt,
                        input logic rv, input logic rt, input logic [63:0] rtgt);
        logic old_flush;
        logic mis;
        ent_t e;
        @(negedge clk);
        bus.fetch_valid = fv; bus.fetch_pc = pc; bus.fetch_pred_taken = pt; bus.fetch_pred_target = ptgt;
        bus.res_valid = rv; bus.res_taken = rt; bus.res_target = rtgt;
        old_flush = m_flush;
        mis = 0;
        m_flush = 0; m_redir = 0; m_en = 0; m_addr = 0; m_wt = 0;
        if (rv) begin
            if (mq.size() == 0) m_err = 1;
            else begin
                e = mq.pop_front();
                m_en = 1;
                m_addr = e.pc[LOWER+1:2];
                m_wt = rt;
                mis = (rt != e.pt) || (rt && rtgt != e.tgt);
                if (mis) begin
                    m_flush = 1;
                    m_redir = rt ? rtgt : e.pc + 64'd4;
                    mq.delete();
                end
            end
        end
        if (fv && !old_flush && !mis) begin
            if (mq.size() < DEPTH) mq.push_back('{pc, pt, ptgt});
            else m_err = 1;
        end
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic idle();
        step(0, 64'h0, 0, 64'h0, 0, 0, 64'h0);
    endtask

    task automatic async_reset(input string tag);
        bus.fetch_valid = 0; bus.res_valid = 0;
        arst_n = 0;
        #1;
        check({tag, "_flush"}, bus.flush, 0);
        check({tag, "_redir"}, bus.redirect_pc, 0);
        check({tag, "_en"}, bus.bht_en, 0);
        check({tag, "_addr"}, bus.bht_write_addr, 0);
        check({tag, "_wt"}, bus.bht_was_taken, 0);
        check({tag, "_count"}, bus.count, 0);
        check({tag, "_full"}, bus.full, 0);
        check({tag, "_err"}, bus.err, 0);
        model_clear();
        @(negedge clk);
        arst_n = 1;
    endtask

    initial begin
        logic [63:0] tgts [4];
        logic        fv, pt, rv, rt;
        logic [63:0] pc, ptgt, rtgt;
        tgts[0] = 64'h80; tgts[1] = 64'h100; tgts[2] = 64'h200; tgts[3] = 64'h1F0;
        bus.fetch_valid = 0; bus.fetch_pc = 0; bus.fetch_pred_taken = 0; bus.fetch_pred_target = 0;
        bus.res_valid = 0; bus.res_taken = 0; bus.res_target = 0;
        model_clear();
        #2;
        async_reset("rst0");

        step(1, 64'h40, 1, 64'h80, 0, 0, 64'h0);
        step(0, 64'h0, 0, 64'h0, 1, 1, 64'h80);
        check("t1_en", bus.bht_en, 1);
        check("t1_addr", bus.bht_write_addr, 64'h10);
        check("t1_wt", bus.bht_was_taken, 1);
        check("t1_flush", bus.flush, 0);

        step(1, 64'h100, 1, 64'h180, 0, 0, 64'h0);
        step(0, 64'h0, 0, 64'h0, 1, 0, 64'h0);
        check("t2_flush", bus.flush, 1);
        check("t2_redir", bus.redirect_pc, 64'h104);
        check("t2_wt", bus.bht_was_taken, 0);
        check("t2_count", bus.count, 0);
        idle();
        check("t2_flush_gone", bus.flush, 0);

        step(1, 64'hFFFF_FFFF_FFFF_FFFC, 1, 64'h10, 0, 0, 64'h0);
        step(0, 64'h0, 0, 64'h0, 1, 0, 64'h0);
        check("t5_redir", bus.redirect_pc, 64'h0);
        check("t5_flush", bus.flush, 1);
        async_reset("rst_flush");

        step(1, 64'h40, 1, 64'h80, 0, 0, 64'h0);
        step(1, 64'h44, 0, 64'h0, 0, 0, 64'h0);
        step(1, 64'h48, 0, 64'h0, 1, 1, 64'h80);
        check("t6_count", bus.count, 2);
        async_reset("rst_mid");

        for (int i = 0; i < 4; i++) step(1, 64'h10 * (i + 1), 1, 64'h80, 0, 0, 64'h0);
        check("t4_full", bus.full, 1);
        step(1, 64'h50, 1, 64'h80, 1, 1, 64'h80);
        check("t4_count", bus.count, 4);
        check("t4_err0", bus.err, 0);
        step(1, 64'h60, 1, 64'h80, 0, 0, 64'h0);
        check("t4_err1", bus.err, 1);
        check("t4_count_keep", bus.count, 4);
        async_reset("rst_b");

        step(1, 64'h300, 1, 64'h1F0, 0, 0, 64'h0);
        step(1, 64'h304, 0, 64'h0, 0, 0, 64'h0);
        step(1, 64'h308, 0, 64'h0, 0, 0, 64'h0);
        step(0, 64'h0, 0, 64'h0, 1, 1, 64'h200);
        check("t3_flush", bus.flush, 1);
        check("t3_redir", bus.redirect_pc, 64'h200);
        check("t3_count", bus.count, 0);
        idle();
        step(0, 64'h0, 0, 64'h0, 1, 1, 64'h200);
        check("t3_err", bus.err, 1);
        check("t3_no_en", bus.bht_en, 0);
        async_reset("rst_c");

        for (int i = 0; i < 600; i++) begin
            fv   = ($urandom % 3) != 0;
            pc   = ($urandom % 8 == 0) ? 64'hFFFF_FFFF_FFFF_FFFC : 64'({$urandom_range(0, 255), 2'b00});
            pt   = $urandom % 2;
            ptgt = tgts[$urandom % 4];
            rv   = ($urandom % 5) < 2;
            rt   = $urandom % 2;
            rtgt = tgts[$urandom % 4];
            if (mq.size() > 0 && ($urandom % 4) != 0) begin
                rt = mq[0].pt;
                rtgt = rt ? mq[0].tgt : rtgt;
            end
            step(fv, pc, pt, ptgt, rv, rt, rtgt);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
